// File: rtl/op_source_arb.sv
// Opcode/operand source arbiter: fixed-select or round-robin grant into a
// one-entry ALU command register, with a drain/commit handshake on mode changes.
module op_source_arb #(
  parameter int NUM_SRC = 2,
  parameter int OPC_W   = 3,
  parameter int OPR_W   = 8,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arb_mode,
  input  logic [SW-1:0]            src_sel,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*OPC_W-1:0] src_opcode,
  input  logic [NUM_SRC*OPR_W-1:0] src_operand,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     alu_valid,
  output logic [OPC_W-1:0]         alu_opcode,
  output logic [OPR_W-1:0]         alu_operand,
  input  logic                     alu_ready,
  output logic [SW-1:0]            active_src,
  output logic                     switching,
  output logic                     sel_err,
  output logic [15:0]              xfer_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [SW:0] NUM_SRC_W = (SW+1)'(NUM_SRC);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [SW-1:0]      active_src_q, active_src_d;
  logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               sel_err_q, sel_err_d;
  logic               sel_blk_q, sel_blk_d;
  logic               alu_valid_q, alu_valid_d;
  logic [OPC_W-1:0]   alu_opcode_q, alu_opcode_d;
  logic [OPR_W-1:0]   alu_operand_q, alu_operand_d;
  logic [15:0]        xfer_cnt_q, xfer_cnt_d;

  logic               free_s, alu_xfer_s, src_xfer_s;
  logic               sel_illegal_s, switch_req_s;
  logic               rr_hit_s, gnt_ok_s;
  logic [SW-1:0]      rr_cand_s, rr_gnt_s, gnt_s;
  logic [NUM_SRC-1:0] ready_s;

  // Grant selection: round-robin search from rr_ptr, or the committed fixed source.
  always_comb begin
    free_s        = !alu_valid_q || alu_ready;
    alu_xfer_s    = alu_valid_q && alu_ready;
    sel_illegal_s = ({1'b0, src_sel} >= NUM_SRC_W);
    switch_req_s  = (arb_mode != mode_q) || (!mode_q && (src_sel != active_src_q));
    rr_hit_s      = 1'b0;
    rr_gnt_s      = '0;
    rr_cand_s     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_cand_s = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!rr_hit_s && src_valid[rr_cand_s]) begin
        rr_hit_s = 1'b1;
        rr_gnt_s = rr_cand_s;
      end else begin
        rr_hit_s = rr_hit_s;
      end
    end
    gnt_s    = mode_q ? rr_gnt_s : active_src_q;
    gnt_ok_s = mode_q ? rr_hit_s : !sel_blk_q;
    ready_s  = '0;
    // A pending mode/source change blocks new grants in the same cycle it is seen.
    if (!reset && (state_q == ST_RUN) && !switch_req_s && gnt_ok_s) begin
      ready_s[gnt_s] = free_s;
    end else begin
      ready_s = '0;
    end
    src_xfer_s = |(ready_s & src_valid);
  end

  // Output command register and transfer counter.
  always_comb begin
    alu_valid_d   = alu_valid_q;
    alu_opcode_d  = alu_opcode_q;
    alu_operand_d = alu_operand_q;
    if (src_xfer_s) begin
      alu_valid_d   = 1'b1;
      alu_opcode_d  = src_opcode[int'(gnt_s)*OPC_W +: OPC_W];
      alu_operand_d = src_operand[int'(gnt_s)*OPR_W +: OPR_W];
    end else if (alu_xfer_s) begin
      alu_valid_d = 1'b0;
    end else begin
      alu_valid_d = alu_valid_q;
    end
    xfer_cnt_d = alu_xfer_s ? (xfer_cnt_q + 16'd1) : xfer_cnt_q;
  end

  // Control FSM: RUN grants, DRAIN empties the register, COMMIT latches the new selection.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    active_src_d = active_src_q;
    rr_ptr_d     = rr_ptr_q;
    sel_err_d    = sel_err_q;
    sel_blk_d    = sel_blk_q;
    case (state_q)
      ST_RUN: begin
        if (mode_q && src_xfer_s) begin
          active_src_d = gnt_s;
          rr_ptr_d     = (gnt_s == SW'(NUM_SRC - 1)) ? '0 : (gnt_s + SW'(1));
        end else begin
          active_src_d = active_src_q;
        end
        state_d = switch_req_s ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        state_d = alu_valid_d ? ST_DRAIN : ST_COMMIT;
      end
      ST_COMMIT: begin
        mode_d  = arb_mode;
        state_d = ST_RUN;
        // An illegal fixed selection keeps the old source but grants nothing.
        if (!arb_mode && sel_illegal_s) begin
          sel_err_d = 1'b1;
          sel_blk_d = 1'b1;
        end else begin
          sel_blk_d    = 1'b0;
          active_src_d = sel_illegal_s ? active_src_q : src_sel;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      mode_q        <= 1'b0;
      active_src_q  <= '0;
      rr_ptr_q      <= '0;
      sel_err_q     <= 1'b0;
      sel_blk_q     <= 1'b0;
      alu_valid_q   <= 1'b0;
      alu_opcode_q  <= '0;
      alu_operand_q <= '0;
      xfer_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      active_src_q  <= active_src_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_err_q     <= sel_err_d;
      sel_blk_q     <= sel_blk_d;
      alu_valid_q   <= alu_valid_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_operand_q <= alu_operand_d;
      xfer_cnt_q    <= xfer_cnt_d;
    end
  end

  assign src_ready   = ready_s;
  assign alu_valid   = alu_valid_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_operand = alu_operand_q;
  assign active_src  = active_src_q;
  assign switching   = (state_q == ST_DRAIN);
  assign sel_err     = sel_err_q;
  assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_op_source_arb.sv
// Directed self-checking bench for op_source_arb: a 2-source instance for the
// main flows and a 3-source instance for out-of-range fixed selection.
module tb_op_source_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_SRC = 2
  logic        reset_a, arb_mode_a, alu_ready_a;
  logic [0:0]  src_sel_a, active_src_a;
  logic [1:0]  src_valid_a, src_ready_a;
  logic [5:0]  src_opcode_a;
  logic [15:0] src_operand_a;
  logic        alu_valid_a, switching_a, sel_err_a;
  logic [2:0]  alu_opcode_a;
  logic [7:0]  alu_operand_a;
  logic [15:0] xfer_cnt_a;

  // Instance B: NUM_SRC = 3
  logic        reset_b, arb_mode_b, alu_ready_b;
  logic [1:0]  src_sel_b, active_src_b;
  logic [2:0]  src_valid_b, src_ready_b;
  logic [8:0]  src_opcode_b;
  logic [23:0] src_operand_b;
  logic        alu_valid_b, switching_b, sel_err_b;
  logic [2:0]  alu_opcode_b;
  logic [7:0]  alu_operand_b;
  logic [15:0] xfer_cnt_b;

  op_source_arb #(.NUM_SRC(2), .OPC_W(3), .OPR_W(8)) u_dut_a (
    .clk(clk), .reset(reset_a), .arb_mode(arb_mode_a), .src_sel(src_sel_a),
    .src_valid(src_valid_a), .src_opcode(src_opcode_a), .src_operand(src_operand_a),
    .src_ready(src_ready_a), .alu_valid(alu_valid_a), .alu_opcode(alu_opcode_a),
    .alu_operand(alu_operand_a), .alu_ready(alu_ready_a), .active_src(active_src_a),
    .switching(switching_a), .sel_err(sel_err_a), .xfer_cnt(xfer_cnt_a)
  );

  op_source_arb #(.NUM_SRC(3), .OPC_W(3), .OPR_W(8)) u_dut_b (
    .clk(clk), .reset(reset_b), .arb_mode(arb_mode_b), .src_sel(src_sel_b),
    .src_valid(src_valid_b), .src_opcode(src_opcode_b), .src_operand(src_operand_b),
    .src_ready(src_ready_b), .alu_valid(alu_valid_b), .alu_opcode(alu_opcode_b),
    .alu_operand(alu_operand_b), .alu_ready(alu_ready_b), .active_src(active_src_b),
    .switching(switching_b), .sel_err(sel_err_b), .xfer_cnt(xfer_cnt_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid"},  32'(alu_valid_a),   32'h0);
    check({tag, "_opc"},    32'(alu_opcode_a),  32'h0);
    check({tag, "_opr"},    32'(alu_operand_a), 32'h0);
    check({tag, "_active"}, 32'(active_src_a),  32'h0);
    check({tag, "_switch"}, 32'(switching_a),   32'h0);
    check({tag, "_selerr"}, 32'(sel_err_a),     32'h0);
    check({tag, "_cnt"},    32'(xfer_cnt_a),    32'h0);
  endtask

  initial begin
    reset_a = 1'b1; arb_mode_a = 1'b0; src_sel_a = 1'b0; alu_ready_a = 1'b0;
    src_valid_a = 2'b11; src_opcode_a = 6'd0; src_operand_a = 16'd0;
    reset_b = 1'b1; arb_mode_b = 1'b0; src_sel_b = 2'd0; alu_ready_b = 1'b1;
    src_valid_b = 3'b111; src_opcode_b = {3'd7, 3'd6, 3'd5};
    src_operand_b = {8'hC2, 8'hB1, 8'hA0};

    // Reset state and ready gating during reset
    repeat (2) tick();
    check("rst_ready_a", 32'(src_ready_a), 32'h0);
    check("rst_ready_b", 32'(src_ready_b), 32'h0);
    reset_a = 1'b0; src_valid_a = 2'b00;
    #1;
    check_reset_a("rst");

    // Single command, 1-cycle latency, counter one cycle later
    src_opcode_a = {3'd0, 3'b101}; src_operand_a = {8'h00, 8'h5A};
    src_valid_a = 2'b01; alu_ready_a = 1'b1;
    #1;
    check("basic_ready", 32'(src_ready_a), 32'h1);
    tick();
    src_valid_a = 2'b00;
    check("basic_valid", 32'(alu_valid_a),   32'h1);
    check("basic_opc",   32'(alu_opcode_a),  32'h5);
    check("basic_opr",   32'(alu_operand_a), 32'h5A);
    check("basic_cnt0",  32'(xfer_cnt_a),    32'h0);
    tick();
    check("basic_cnt1",  32'(xfer_cnt_a),    32'h1);
    check("basic_empty", 32'(alu_valid_a),   32'h0);

    // Backpressure: hold A for 3 cycles, then stream B, C in order
    alu_ready_a = 1'b0; src_valid_a = 2'b01;
    src_opcode_a = {3'd0, 3'd1}; src_operand_a = {8'h00, 8'h11};
    tick();
    src_opcode_a = {3'd0, 3'd2}; src_operand_a = {8'h00, 8'h22};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 32'(src_ready_a),   32'h0);
      check("bp_opc",   32'(alu_opcode_a),  32'h1);
      check("bp_opr",   32'(alu_operand_a), 32'h11);
      tick();
    end
    alu_ready_a = 1'b1;
    #1;
    check("bp_resume_ready", 32'(src_ready_a), 32'h1);
    tick();
    check("bp_b_opc", 32'(alu_opcode_a),  32'h2);
    check("bp_b_opr", 32'(alu_operand_a), 32'h22);
    check("bp_b_cnt", 32'(xfer_cnt_a),    32'h2);
    src_opcode_a = {3'd0, 3'd3}; src_operand_a = {8'h00, 8'h33};
    tick();
    check("bp_c_opc", 32'(alu_opcode_a),  32'h3);
    check("bp_c_opr", 32'(alu_operand_a), 32'h33);
    src_valid_a = 2'b00;
    tick();
    check("bp_end_valid", 32'(alu_valid_a), 32'h0);
    check("bp_end_cnt",   32'(xfer_cnt_a),  32'h4);

    // Source switch with a held command: drain, commit, then grant source 1
    alu_ready_a = 1'b0; src_valid_a = 2'b01;
    src_opcode_a = {3'd0, 3'd4}; src_operand_a = {8'h00, 8'h44};
    tick();
    src_valid_a = 2'b00; src_sel_a = 1'b1;
    #1;
    check("sw_req_ready", 32'(src_ready_a), 32'h0);
    tick();
    check("sw_drain",       32'(switching_a),  32'h1);
    check("sw_drain_held",  32'(alu_opcode_a), 32'h4);
    src_valid_a = 2'b10; src_opcode_a = {3'd6, 3'd0}; src_operand_a = {8'h66, 8'h00};
    tick();
    check("sw_drain2",      32'(switching_a), 32'h1);
    check("sw_drain_ready", 32'(src_ready_a), 32'h0);
    alu_ready_a = 1'b1;
    tick();
    check("sw_commit_switch", 32'(switching_a),  32'h0);
    check("sw_commit_ready",  32'(src_ready_a),  32'h0);
    check("sw_commit_valid",  32'(alu_valid_a),  32'h0);
    check("sw_commit_cnt",    32'(xfer_cnt_a),   32'h5);
    tick();
    check("sw_active", 32'(active_src_a), 32'h1);
    check("sw_ready1", 32'(src_ready_a),  32'h2);
    tick();
    check("sw_e_opc", 32'(alu_opcode_a),  32'h6);
    check("sw_e_opr", 32'(alu_operand_a), 32'h66);
    src_valid_a = 2'b00;
    tick();

    // Round-robin: both valid, grants alternate 0,1,0,1
    arb_mode_a = 1'b1;
    tick();
    check("rr_drain", 32'(switching_a), 32'h1);
    repeat (2) tick();
    check("rr_run", 32'(switching_a), 32'h0);
    src_valid_a = 2'b11; src_opcode_a = {3'd2, 3'd1}; src_operand_a = {8'hB1, 8'hA0};
    #1;
    check("rr_first_ready", 32'(src_ready_a), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_opc",    32'(alu_opcode_a), 32'((i % 2) + 1));
      check("rr_active", 32'(active_src_a), 32'(i % 2));
      check("rr_ready",  32'(src_ready_a),  (i % 2 == 0) ? 32'h2 : 32'h1);
    end
    src_valid_a = 2'b00;
    tick();
    check("rr_cnt", 32'(xfer_cnt_a), 32'hA);

    // Counter wrap after 65537 transfers, then reset mid-DRAIN
    arb_mode_a = 1'b0; src_sel_a = 1'b0; reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("wrap_start", 32'(xfer_cnt_a), 32'h0);
    src_valid_a = 2'b01; alu_ready_a = 1'b1;
    src_opcode_a = {3'd0, 3'd7}; src_operand_a = {8'h00, 8'hFF};
    repeat (65536) tick();
    check("wrap_ffff", 32'(xfer_cnt_a), 32'hFFFF);
    repeat (2) tick();
    check("wrap_0001", 32'(xfer_cnt_a), 32'h1);
    alu_ready_a = 1'b0;
    tick();
    src_valid_a = 2'b00; src_sel_a = 1'b1;
    tick();
    check("mid_drain",  32'(switching_a), 32'h1);
    check("mid_held",   32'(alu_valid_a), 32'h1);
    reset_a = 1'b1; src_valid_a = 2'b11;
    #1;
    check("mid_rst_ready", 32'(src_ready_a), 32'h0);
    tick();
    check_reset_a("mid_rst");
    reset_a = 1'b0; src_sel_a = 1'b0; src_valid_a = 2'b00;

    // 3-source instance: out-of-range fixed selection, then recovery
    reset_b = 1'b0; src_sel_b = 2'd3;
    repeat (3) tick();
    check("oor_selerr", 32'(sel_err_b),    32'h1);
    check("oor_active", 32'(active_src_b), 32'h0);
    check("oor_ready",  32'(src_ready_b),  32'h0);
    check("oor_valid",  32'(alu_valid_b),  32'h0);
    tick();
    check("oor_ready2", 32'(src_ready_b),  32'h0);
    src_sel_b = 2'd2;
    repeat (4) tick();
    check("rec_active", 32'(active_src_b),  32'h2);
    check("rec_selerr", 32'(sel_err_b),     32'h1);
    check("rec_ready",  32'(src_ready_b),   32'h4);
    check("rec_valid",  32'(alu_valid_b),   32'h1);
    check("rec_opc",    32'(alu_opcode_b),  32'h7);
    check("rec_opr",    32'(alu_operand_b), 32'hC2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
